// File: rtl/hough_result_tx.sv
// ---------------------------------------------------------------------------
// hough_result_tx
//
// Captures the Hough line detector's results on each `done` pulse and
// serialises them as a framed byte packet for the UART transmitter:
//   SYNC_BYTE, N, {rho, theta, votes} x N (slot order), CHK
// where N = min(num_lines, MAX_LINES) and CHK = XOR of N and all payload bytes.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   done                        one-cycle result-valid pulse from the detector
//   num_lines                   number of valid line slots reported
//   line_rho/theta/votes_0..3   per-slot line results
//   tx_data, tx_valid, tx_ready byte stream with valid/ready handshake
//   busy                        packet being captured or sent
//   pkt_sent                    one-cycle pulse after the CHK byte is accepted
//   overrun                     sticky: a done pulse arrived while busy
// ---------------------------------------------------------------------------
module hough_result_tx #(
    parameter int         MAX_LINES = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done,
    input  logic [7:0] num_lines,
    input  logic [7:0] line_rho_0,
    input  logic [7:0] line_rho_1,
    input  logic [7:0] line_rho_2,
    input  logic [7:0] line_rho_3,
    input  logic [7:0] line_theta_0,
    input  logic [7:0] line_theta_1,
    input  logic [7:0] line_theta_2,
    input  logic [7:0] line_theta_3,
    input  logic [7:0] line_votes_0,
    input  logic [7:0] line_votes_1,
    input  logic [7:0] line_votes_2,
    input  logic [7:0] line_votes_3,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       pkt_sent,
    output logic       overrun
);

    localparam logic [7:0] MAX_N = 8'(MAX_LINES);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        COUNT,
        PAYLOAD,
        CHK
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] n_lines;
    logic [7:0] rho_s   [0:3];
    logic [7:0] theta_s [0:3];
    logic [7:0] votes_s [0:3];
    logic [1:0] field;      // 0 = rho, 1 = theta, 2 = votes
    logic [1:0] slot;
    logic [7:0] chk;
    logic       capture;
    logic       xfer;
    logic       last_payload;

    // Every non-IDLE state presents a byte, so valid and busy coincide.
    assign tx_valid     = (state != IDLE);
    assign busy         = tx_valid;
    assign xfer         = tx_valid && tx_ready;
    assign last_payload = (field == 2'd2) && ({6'd0, slot} == (n_lines - 8'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_data   = 8'h00;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (done) begin
                    capture   = 1'b1;
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) state_nxt = COUNT;
            end
            COUNT: begin
                tx_data = n_lines;
                if (tx_ready) state_nxt = (n_lines == 8'd0) ? CHK : PAYLOAD;
            end
            PAYLOAD: begin
                case (field)
                    2'd0:    tx_data = rho_s[slot];
                    2'd1:    tx_data = theta_s[slot];
                    2'd2:    tx_data = votes_s[slot];
                    default: tx_data = 8'h00;
                endcase
                if (tx_ready && last_payload) state_nxt = CHK;
            end
            CHK: begin
                tx_data = chk;
                if (tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_lines  <= 8'd0;
            field    <= 2'd0;
            slot     <= 2'd0;
            chk      <= 8'd0;
            pkt_sent <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rho_s[i]   <= 8'd0;
                theta_s[i] <= 8'd0;
                votes_s[i] <= 8'd0;
            end
        end else begin
            pkt_sent <= (state == CHK) && xfer;
            // A done that finds us mid-packet is dropped, not queued.
            if (done && (state != IDLE)) overrun <= 1'b1;

            if (capture) begin
                n_lines    <= (num_lines > MAX_N) ? MAX_N : num_lines;
                field      <= 2'd0;
                slot       <= 2'd0;
                chk        <= 8'd0;
                rho_s[0]   <= line_rho_0;
                rho_s[1]   <= line_rho_1;
                rho_s[2]   <= line_rho_2;
                rho_s[3]   <= line_rho_3;
                theta_s[0] <= line_theta_0;
                theta_s[1] <= line_theta_1;
                theta_s[2] <= line_theta_2;
                theta_s[3] <= line_theta_3;
                votes_s[0] <= line_votes_0;
                votes_s[1] <= line_votes_1;
                votes_s[2] <= line_votes_2;
                votes_s[3] <= line_votes_3;
            end else if (xfer) begin
                // SYNC is excluded from the checksum; COUNT and payload fold in.
                if ((state == COUNT) || (state == PAYLOAD)) chk <= chk ^ tx_data;
                if (state == PAYLOAD) begin
                    if (field == 2'd2) begin
                        field <= 2'd0;
                        slot  <= slot + 2'd1;
                    end else begin
                        field <= field + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hough_result_tx.sv
module tb_hough_result_tx;

    logic       clk = 1'b0;
    logic       reset, done, tx_ready;
    logic [7:0] num_lines;
    logic [7:0] rho [0:3];
    logic [7:0] theta [0:3];
    logic [7:0] votes [0:3];
    logic [7:0] tx_data;
    logic       tx_valid, busy, pkt_sent, overrun;

    int         checks   = 0;
    int         errors   = 0;
    int         byte_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    hough_result_tx dut (
        .clk(clk), .reset(reset), .done(done), .num_lines(num_lines),
        .line_rho_0(rho[0]), .line_rho_1(rho[1]), .line_rho_2(rho[2]), .line_rho_3(rho[3]),
        .line_theta_0(theta[0]), .line_theta_1(theta[1]),
        .line_theta_2(theta[2]), .line_theta_3(theta[3]),
        .line_votes_0(votes[0]), .line_votes_1(votes[1]),
        .line_votes_2(votes[2]), .line_votes_3(votes[3]),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .pkt_sent(pkt_sent), .overrun(overrun)
    );

    // Reference packet built from the inputs as they are when done is driven.
    task automatic push_packet();
        logic [7:0] n, c;
        n = (num_lines > 8'd4) ? 8'd4 : num_lines;
        exp_q.push_back(8'hA5);
        exp_q.push_back(n);
        c = n;
        for (int s = 0; s < int'(n); s++) begin
            exp_q.push_back(rho[s]);   c = c ^ rho[s];
            exp_q.push_back(theta[s]); c = c ^ theta[s];
            exp_q.push_back(votes[s]); c = c ^ votes[s];
        end
        exp_q.push_back(c);
    endtask

    task automatic set_inputs(input logic [7:0] n, input logic [7:0] v [0:11]);
        num_lines = n;
        for (int s = 0; s < 4; s++) begin
            rho[s]   = v[3*s];
            theta[s] = v[3*s+1];
            votes[s] = v[3*s+2];
        end
    endtask

    task automatic fill_random();
        for (int s = 0; s < 4; s++) begin
            rho[s]   = 8'($urandom_range(0, 255));
            theta[s] = 8'($urandom_range(0, 255));
            votes[s] = 8'($urandom_range(0, 255));
        end
    endtask

    // Observes the byte stream between edges: every accepted byte is popped
    // from the scoreboard, and a stalled byte must be held until accepted.
    task automatic monitor();
        logic [7:0] held = 8'h00;
        logic [7:0] exp;
        bit         stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (tx_valid !== 1'b1 || tx_data !== held) begin
                        errors++;
                        $display("FAIL stall_hold got valid=%b data=%h required valid=1 data=%h",
                                 tx_valid, tx_data, held);
                    end
                end
                if (tx_valid && tx_ready) begin
                    byte_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte got %h required none", tx_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (tx_data !== exp) begin
                            errors++;
                            $display("FAIL byte got %h required %h", tx_data, exp);
                        end
                    end
                    stalled = 1'b0;
                end else if (tx_valid) begin
                    stalled = 1'b1;
                    held    = tx_data;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int budget, input bit rand_ready, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; done = 1'b0; tx_ready = 1'b0; num_lines = 8'd0;
        for (int s = 0; s < 4; s++) begin rho[s] = 0; theta[s] = 0; votes[s] = 0; end
        repeat (2) @(posedge clk); #1;
        checks += 5;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h required 00", tx_data); end
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b required 0", tx_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        if (pkt_sent !== 1'b0) begin errors++; $display("FAIL reset_pkt_sent got %b required 0", pkt_sent); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b required 0", overrun); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        int busy_cycles = 0, sent_cnt = 0, sent_at = -1;
        num_lines = 8'd0; tx_ready = 1'b1;
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (pkt_sent) begin sent_cnt++; sent_at = i; end
        end
        checks += 4;
        if (busy_cycles != 3) begin errors++; $display("FAIL empty_busy_cycles got %0d required 3", busy_cycles); end
        if (sent_cnt != 1) begin errors++; $display("FAIL empty_pkt_sent_count got %0d required 1", sent_cnt); end
        if (sent_at != 3) begin errors++; $display("FAIL empty_pkt_sent_cycle got %0d required 3", sent_at); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL empty_left got %0d required 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [7:0] v [0:11] = '{8'd8, 8'd8, 8'd16, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int  start_cnt;
        bit  ok;
        set_inputs(8'd1, v);
        start_cnt = byte_cnt;
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        num_lines = 8'd0;
        for (int s = 0; s < 4; s++) begin rho[s] = 0; theta[s] = 0; votes[s] = 0; end
        drain(40, 1'b0, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL single_drain got timeout required done"); end
        if (byte_cnt - start_cnt != 6) begin
            errors++; $display("FAIL single_len got %0d required 6", byte_cnt - start_cnt);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [7:0] v [0:11] = '{8'd4, 8'd8, 8'd9, 8'd12, 8'd0, 8'd9, 0, 0, 0, 0, 0, 0};
        bit ok = 1'b0;
        set_inputs(8'd2, v);
        push_packet();
        tx_ready = 1'b1;
        done = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 done = 1'b0;
            if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
            tx_ready = (i < 10) ? ~tx_ready : 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
        checks++;
        if (!ok) begin errors++; $display("FAIL backpressure_drain got timeout required done"); end
    endtask

    task automatic test_clamp();
        int start_cnt;
        bit ok;
        num_lines = 8'd6;
        fill_random();
        start_cnt = byte_cnt;
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        drain(300, 1'b1, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL clamp_drain got timeout required done"); end
        if (byte_cnt - start_cnt != 15) begin
            errors++; $display("FAIL clamp_len got %0d required 15", byte_cnt - start_cnt);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        tx_ready = 1'b1;
        num_lines = 8'd2;
        fill_random();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got %b required 0", overrun); end
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;        // captured
        repeat (3) @(posedge clk); #1;          // SYNC, N, rho0 accepted
        num_lines = 8'd3; fill_random(); done = 1'b1;
        @(posedge clk); #1 done = 1'b0;        // dropped during payload
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_payload got %b required 1", overrun); end
        repeat (4) @(posedge clk); #1;          // now presenting CHK
        fill_random(); done = 1'b1;
        @(posedge clk); #1 done = 1'b0;        // CHK handshake edge, done dropped
        checks += 3;
        if (pkt_sent !== 1'b1) begin errors++; $display("FAIL overrun_pkt_sent got %b required 1", pkt_sent); end
        if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy_after got %b required 0", busy); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b required 1", overrun); end
        num_lines = 8'd3; fill_random();
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;        // accepted right after pkt_sent
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL overrun_restart_busy got %b required 1", busy); end
        drain(100, 1'b0, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL overrun_drain got timeout required done"); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_final got %b required 1", overrun); end
    endtask

    task automatic test_reset_mid_payload();
        bit ok;
        tx_ready = 1'b1;
        num_lines = 8'd4;
        fill_random();
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks += 4;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid got %b required 0", tx_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b required 0", overrun); end
        if (pkt_sent !== 1'b0) begin errors++; $display("FAIL rstmid_pkt_sent got %b required 0", pkt_sent); end
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        num_lines = 8'd3;
        fill_random();
        push_packet();
        done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        drain(300, 1'b1, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rstmid_drain got timeout required done"); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun_after got %b required 0", overrun); end
    endtask

    initial begin
        fork
            monitor();
            begin
                test_reset();
                test_empty();
                test_single();
                test_back_to_back_backpressure();
                test_clamp();
                test_overrun();
                test_reset_mid_payload();
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
